// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared pipeline-control types and sizes for the ARM-style core.
// Pure declarations; no latency or flow control.
package arm_pipe_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_reg_busy_counter.sv
// Per-register in-flight writer counter with saturate/zero flags.
// Latency: 1 cycle; no backpressure, inc is ignored at saturation and dec at zero.
module reg_busy_counter #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             zero
);

    logic inc_ok;
    logic dec_ok;

    assign sat    = &cnt;
    assign zero   = (cnt == '0);
    assign inc_ok = inc & ~sat;
    assign dec_ok = dec & ~zero;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Scoreboard hazard detection plus flush/freeze sequencing beside the ID stage.
// Latency: hazard/freeze_all combinational, flush registered; mem_busy holds the whole pipe.
module hazard_scoreboard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int WB_BYPASS    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic                  id_wb_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    output logic                  hazard,
    output logic                  flush,
    output logic                  freeze_all,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [15:0]           stall_count
);

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    ctrl_state_t         state;
    logic [2:0]          flush_ctr;
    logic                br_pend;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] sat;
    logic [NUM_REGS-1:0] zero;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                issue;
    logic                retire;

    assign flush      = RST & (state == FLUSH);
    assign freeze_all = RST & ((state == MEM_WAIT) | mem_busy);

    // A last writer retiring this cycle satisfies the read via the WB bypass.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = ~zero[r] & ~((WB_BYPASS != 0) & wb_en & (wb_dest == REG_ADDR_W'(r))
                                   & (cnt[r] == CNT_W'(1)) & ~freeze_all);
        end
    end

    assign hazard = RST & id_valid & ~flush
                  & (busy[id_src1] | (id_two_src & busy[id_src2]) | (id_wb_en & sat[id_dest]));
    assign issue  = id_valid & id_wb_en & ~hazard & ~flush & ~freeze_all;
    assign retire = wb_en & ~freeze_all;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        assign inc[g]       = issue & (id_dest == REG_ADDR_W'(g));
        assign dec[g]       = retire & (wb_dest == REG_ADDR_W'(g));
        assign busy_mask[g] = ~zero[g];

        reg_busy_counter #(.CNT_W(CNT_W)) u_cnt (
            .CLK  (CLK),
            .RST  (RST),
            .inc  (inc[g]),
            .dec  (dec[g]),
            .cnt  (cnt[g]),
            .sat  (sat[g]),
            .zero (zero[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= RUN;
            flush_ctr   <= 3'd0;
            br_pend     <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (hazard && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state <= MEM_WAIT;
                        if (branch_taken) begin
                            br_pend   <= 1'b1;
                            flush_ctr <= FC;
                        end
                    end else if (branch_taken) begin
                        state     <= FLUSH;
                        flush_ctr <= FC;
                    end
                end
                MEM_WAIT: begin
                    if (branch_taken) begin
                        br_pend   <= 1'b1;
                        flush_ctr <= FC;
                    end
                    if (!mem_busy) begin
                        if (br_pend || branch_taken) begin
                            state   <= FLUSH;
                            br_pend <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        flush_ctr <= FC;
                    end
                    // The remaining flush count survives a memory stall.
                    if (mem_busy) begin
                        state   <= MEM_WAIT;
                        br_pend <= 1'b1;
                    end else if (!branch_taken) begin
                        flush_ctr <= flush_ctr - 3'd1;
                        if (flush_ctr <= 3'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
